wb_trace_buffer: RTL
====================

# wb_trace_buffer

Synthesizable, parametrised write-back trace buffer for the pipelined RISC-V CPU. It replaces per-cycle `$display` probing of the MEM/WB stage with on-chip capture. Each valid MEM/WB record (pc, alu_out, wb_sel) is stored in a circular buffer of `DEPTH` entries, oldest overwritten first. Capture stops on a freeze request, or on a PC-match trigger plus post-trigger window; a bench or debug port then drains the buffer oldest-first over a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, width of pc and alu_out fields
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `WB_SEL_W`, 3, width of wb_sel field
- `POST_TRIG`, 8, records captured after the trigger record (only with `TRACE_TRIGGER_EN`); 0 ≤ `POST_TRIG` < `DEPTH`

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cap_valid`  in  1  MEM/WB record valid this cycle
- `cap_pc`  in  XLEN  mem_wb_pc
- `cap_alu_out`  in  XLEN  mem_wb_alu_out
- `cap_wb_sel`  in  WB_SEL_W  mem_wb_wb_sel
- `arm`  in  1  start capture (honoured only in IDLE)
- `freeze`  in  1  stop capture, enter DRAIN (honoured in CAPTURE/POST)
- `trig_pc`  in  XLEN  trigger address (present only with `TRACE_TRIGGER_EN`)
- `rd_ready`  in  1  consumer accepts rd entry
- `rd_valid`  out  1  rd entry valid
- `rd_pc`, `rd_alu_out`  out  XLEN  oldest entry fields
- `rd_wb_sel`  out  WB_SEL_W  oldest entry field
- `count`  out  clog2(DEPTH)+1  entries held, 0..DEPTH
- `wrapped`  out  1  sticky: an entry was overwritten since last arm
- `state`  out  2  IDLE=0, CAPTURE=1, POST=2, DRAIN=3

## Operation
- IDLE: no capture, rd_valid=0. `arm` → CAPTURE; clears wr_ptr, count, wrapped.
- CAPTURE: each cycle with `cap_valid`=1 writes record at wr_ptr, wr_ptr+1 mod DEPTH; count saturates at DEPTH; write with count==DEPTH sets `wrapped`.
- Trigger (macro on): in CAPTURE, `cap_valid` && `cap_pc`==`trig_pc` → record captured, remaining=POST_TRIG, go POST (or DRAIN if POST_TRIG=0).
- POST: captures as CAPTURE; each capture decrements remaining; capture taking remaining 1→0 → DRAIN.
- `freeze` in CAPTURE/POST → DRAIN; a record valid in the same cycle is still captured. freeze beats trigger when simultaneous.
- DRAIN: no capture. rd_valid = (count≠0). Oldest index = wr_ptr − count mod DEPTH. rd_valid && rd_ready pops: count−1. Entering/being in DRAIN with count==0 → IDLE next edge.
- `arm`/`freeze` outside their states ignored; `cap_valid` ignored in IDLE/DRAIN.
- rd_pc/rd_alu_out/rd_wb_sel = 0 whenever rd_valid=0.

## Timing
- Reset (reset=0, async): state=IDLE, count=0, wrapped=0, rd_valid=0, rd_* =0, pointers 0; storage contents don't care. Reset mid-capture or mid-drain discards everything.
- Capture latency: record presented at edge N is counted at edge N (count visible cycle N+1).
- freeze sampled at edge N → state=DRAIN and rd_valid=1 (if count>0) in cycle N+1.
- Read data combinational from state/pointers; pop at edge where rd_valid&&rd_ready; next entry valid in following cycle (1 entry/cycle throughput).
- rd_valid must not drop without a pop except via reset.

## Configuration
- `TRACE_TRIGGER_EN` defined: `trig_pc` port, PC-match trigger and POST state present.
- Undefined: no `trig_pc` port, POST unreachable; capture ends only on `freeze`; `POST_TRIG` unused.

## Test plan
- Arm, 5 records pc=0x00,0x04..0x10, freeze → count=5, wrapped=0, drain yields pcs 0x00..0x10 in order, then state=IDLE.
- DEPTH=16, 20 records pc=4·i, freeze → count=16, wrapped=1, drain yields pc=0x10..0x4C.
- Trigger on (POST_TRIG=8), trig_pc=0x40, records pc=4·i for i=0..30 → DRAIN after pc=0x60; last drained entry pc=0x60, first pc=0x24.
- freeze with cap_valid=1 pc=0x80 same cycle → 0x80 is last drained entry; freeze in IDLE → state stays 0.
- Drain with rd_ready toggling 1,0,1 → one pop per asserted cycle, rd_pc stable while rd_ready=0.
- reset low mid-drain (count=7) → asynchronously state=0, count=0, rd_valid=0; subsequent arm works normally.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
//
// On-chip capture of MEM/WB write-back records for the pipelined RISC-V CPU.
// Each valid record (pc, alu_out, wb_sel) is written into a circular buffer
// of DEPTH entries, with the oldest entry overwritten first. Capture stops on
// a freeze request, or (optionally) on a PC-match trigger followed by a
// post-trigger window. The buffer is then drained oldest-first over a
// valid/ready handshake.
//
// Optional feature macro: TRACE_TRIGGER_EN
//   defined   -> trig_pc port, PC-match trigger and POST state are present
//   undefined -> capture ends only on freeze; POST_TRIG is unused
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset
//   cap_valid    in   MEM/WB record valid this cycle
//   cap_pc       in   [XLEN-1:0]     record pc
//   cap_alu_out  in   [XLEN-1:0]     record alu_out
//   cap_wb_sel   in   [WB_SEL_W-1:0] record wb_sel
//   arm          in   start capture (honoured only in IDLE)
//   freeze       in   stop capture and drain (honoured in CAPTURE/POST)
//   trig_pc      in   [XLEN-1:0]     trigger address (TRACE_TRIGGER_EN only)
//   rd_ready     in   consumer accepts the presented entry
//   rd_valid     out  entry presented on rd_* is valid
//   rd_pc        out  [XLEN-1:0]     oldest entry pc (0 when !rd_valid)
//   rd_alu_out   out  [XLEN-1:0]     oldest entry alu_out (0 when !rd_valid)
//   rd_wb_sel    out  [WB_SEL_W-1:0] oldest entry wb_sel (0 when !rd_valid)
//   count        out  [clog2(DEPTH):0] entries held, 0..DEPTH
//   wrapped      out  sticky: an entry was overwritten since last arm
//   state        out  [1:0] IDLE=0, CAPTURE=1, POST=2, DRAIN=3
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int WB_SEL_W  = 3,
  parameter int POST_TRIG = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cap_valid,
  input  logic [XLEN-1:0]           cap_pc,
  input  logic [XLEN-1:0]           cap_alu_out,
  input  logic [WB_SEL_W-1:0]       cap_wb_sel,
  input  logic                      arm,
  input  logic                      freeze,
`ifdef TRACE_TRIGGER_EN
  input  logic [XLEN-1:0]           trig_pc,
`endif
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [XLEN-1:0]           rd_pc,
  output logic [XLEN-1:0]           rd_alu_out,
  output logic [WB_SEL_W-1:0]       rd_wb_sel,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      wrapped,
  output logic [1:0]                state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Elaboration-time parameter sanity checks.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wb_trace_buffer: DEPTH must be a power of two >= 2");
    end
    if ((POST_TRIG < 0) || (POST_TRIG >= DEPTH)) begin : g_bad_post
      $error("wb_trace_buffer: POST_TRIG must satisfy 0 <= POST_TRIG < DEPTH");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wrapped_q, wrapped_d;
  logic              wr_en_s;
  logic [AW-1:0]     rd_idx_s;
  logic              rd_valid_s;

  logic [XLEN-1:0]     mem_pc_q  [DEPTH];
  logic [XLEN-1:0]     mem_alu_q [DEPTH];
  logic [WB_SEL_W-1:0] mem_sel_q [DEPTH];

`ifdef TRACE_TRIGGER_EN
  localparam logic [AW-1:0] POST_TRIG_C = AW'(POST_TRIG);
  localparam bit            POST_ZERO   = (POST_TRIG == 0);

  logic [AW-1:0] rem_q, rem_d;
  logic          trig_hit_s;

  // Trigger fires on a valid record whose pc matches the trigger address.
  assign trig_hit_s = cap_valid && (cap_pc == trig_pc);
`else
  // POST_TRIG has no role without the trigger feature.
  logic [AW-1:0] unused_post_trig_s;
  assign unused_post_trig_s = AW'(POST_TRIG);
`endif

  // Next-state computation for the capture/drain controller.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    wr_en_s   = 1'b0;
`ifdef TRACE_TRIGGER_EN
    rem_d     = rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_CAPTURE;
          wr_ptr_d  = {AW{1'b0}};
          count_d   = {CW{1'b0}};
          wrapped_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE, ST_POST: begin
        wr_en_s = cap_valid;
        if (cap_valid) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          // A write into a full buffer drops the oldest entry.
          if (count_q == DEPTH_C) begin
            wrapped_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        // freeze has priority over the trigger path.
        if (freeze) begin
          state_d = ST_DRAIN;
        end
`ifdef TRACE_TRIGGER_EN
        else if ((state_q == ST_CAPTURE) && trig_hit_s) begin
          rem_d   = POST_TRIG_C;
          state_d = POST_ZERO ? ST_DRAIN : ST_POST;
        end else if ((state_q == ST_POST) && cap_valid) begin
          rem_d = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_POST;
          end
        end
`endif
        else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (count_q == {CW{1'b0}}) begin
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          count_d = count_q - CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset discards any capture or drain in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      wrapped_q <= 1'b0;
`ifdef TRACE_TRIGGER_EN
      rem_q     <= {AW{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
`ifdef TRACE_TRIGGER_EN
      rem_q     <= rem_d;
`endif
    end
  end

  // Record storage; contents are irrelevant until counted, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_pc_q[wr_ptr_q]  <= cap_pc;
      mem_alu_q[wr_ptr_q] <= cap_alu_out;
      mem_sel_q[wr_ptr_q] <= cap_wb_sel;
    end
  end

  // Oldest entry sits count places behind the write pointer (mod DEPTH);
  // a full buffer wraps this to the write pointer itself.
  assign rd_idx_s   = wr_ptr_q - count_q[AW-1:0];
  assign rd_valid_s = (state_q == ST_DRAIN) && (count_q != {CW{1'b0}});

  // Read port: oldest entry while valid, zeros otherwise.
  always_comb begin
    if (rd_valid_s) begin
      rd_pc      = mem_pc_q[rd_idx_s];
      rd_alu_out = mem_alu_q[rd_idx_s];
      rd_wb_sel  = mem_sel_q[rd_idx_s];
    end else begin
      rd_pc      = {XLEN{1'b0}};
      rd_alu_out = {XLEN{1'b0}};
      rd_wb_sel  = {WB_SEL_W{1'b0}};
    end
  end

  assign rd_valid = rd_valid_s;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign state    = state_q;

endmodule
